// File: rtl/ram8_16_if.sv
// ram8_16_if -- bus bundle for the RAM8 register file.
//   in      : write data            (master -> slave)
//   load    : write enable          (master -> slave)
//   address : word select, R and W  (master -> slave)
//   out     : combinational read    (slave -> master)
interface ram8_16_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
);
    logic [WIDTH-1:0] in;
    logic             load;
    logic [AW-1:0]    address;
    logic [WIDTH-1:0] out;

    modport master (output in, output load, output address, input out);
    modport slave  (input in, input load, input address, output out);
endinterface

// File: rtl/ram8_16.sv
// ram8_16 -- eight-word by 16-bit register file (RAM8).
// Leaf memory for the RAM64/RAM512 hierarchy: synchronous write,
// asynchronous read, synchronous active-high clear of every word.
//   clk   : system clock, state updates on rising edge
//   reset : synchronous active-high, clears all words (beats load)
//   bus   : ram8_16_if.slave -- in/load/address in, out = word[address]

// 8-way load steering: exactly one strobe follows load, the rest are 0.
module ram8_16_demux #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             load,
    input  logic [AW-1:0]    sel,
    output logic [DEPTH-1:0] strobe
);
    always_comb begin
        strobe      = '0;
        strobe[sel] = load;
    end
endmodule

// One storage word. Reset wins over load so a write in a reset cycle is dropped.
module ram8_16_word #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk) begin
        if (reset)
            q <= '0;
        else if (load)
            q <= d;
    end
endmodule

// 8-way read mux; every address code maps to a word, so no default case.
module ram8_16_mux #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic [AW-1:0]                sel,
    input  logic [DEPTH-1:0][WIDTH-1:0]  data,
    output logic [WIDTH-1:0]             y
);
    assign y = data[sel];
endmodule

module ram8_16 #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    ram8_16_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0]            strobe;
    logic [DEPTH-1:0][WIDTH-1:0] word;

    ram8_16_demux #(.DEPTH(DEPTH), .AW(AW)) u_demux (
        .load   (bus.load),
        .sel    (bus.address),
        .strobe (strobe)
    );

    for (genvar g = 0; g < DEPTH; g++) begin : g_word
        ram8_16_word #(.WIDTH(WIDTH)) u_word (
            .clk   (clk),
            .reset (reset),
            .load  (strobe[g]),
            .d     (bus.in),
            .q     (word[g])
        );
    end

    // Read path has no bypass: during a write the old contents show until the edge.
    ram8_16_mux #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mux (
        .sel  (bus.address),
        .data (word),
        .y    (bus.out)
    );
endmodule

// File: tb/tb_ram8_16.sv
module tb_ram8_16;
    logic clk = 1'b0;
    logic reset;
    int   nchk = 0;
    int   nfail = 0;

    logic [15:0] model [8];
    logic [15:0] sb [$];

    ram8_16_if bus ();

    ram8_16 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Pop the oldest expected value and compare against the live read port.
    task automatic check(input string tag);
        logic [15:0] exp;
        if (sb.size() == 0) begin
            nchk++;
            nfail++;
            $error("FAIL %s: observed empty scoreboard expected entry", tag);
            return;
        end
        exp = sb.pop_front();
        nchk++;
        assert (bus.out === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, bus.out, exp);
        end
    endtask

    task automatic rd(input logic [2:0] a, input string tag);
        bus.address = a;
        sb.push_back(model[a]);
        #1;
        check(tag);
    endtask

    task automatic scan(input string tag);
        for (int i = 0; i < 8; i++) rd(3'(i), tag);
    endtask

    // Write one word; check it is visible right after the edge.
    task automatic wr(input logic [2:0] a, input logic [15:0] d, input string tag);
        bus.address = a;
        bus.in      = d;
        bus.load    = 1'b1;
        @(posedge clk);
        #1;
        bus.load = 1'b0;
        model[a] = d;
        sb.push_back(d);
        check(tag);
    endtask

    initial begin
        reset       = 1'b1;
        bus.load    = 1'b0;
        bus.in      = '0;
        bus.address = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) model[i] = 16'h0000;

        // Reset then scan
        scan("reset_scan");

        // Fill: word[i] = 0x1111*i + 1
        for (int i = 0; i < 8; i++) wr(3'(i), 16'(16'h1111 * i + 16'h0001), "fill_wr");
        for (int i = 0; i < 8; i++) begin
            bus.address = 3'(i);
            sb.push_back(16'(16'h1111 * i + 16'h0001));
            #1;
            check("fill_rd");
        end

        // Write isolation
        wr(3'd5, 16'hFFFF, "iso_wr");
        scan("iso_scan");

        // Read-during-write on the same address
        wr(3'd3, 16'hAAAA, "rdw_prep");
        bus.address = 3'd3;
        bus.in      = 16'h5555;
        bus.load    = 1'b1;
        sb.push_back(16'hAAAA);
        #1;
        check("rdw_before");
        @(posedge clk);
        #1;
        bus.load = 1'b0;
        model[3] = 16'h5555;
        sb.push_back(16'h5555);
        check("rdw_after");

        // Load low: sweep the address over 8 edges, nothing changes
        bus.in   = 16'hDEAD;
        bus.load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.address = 3'(i);
            @(posedge clk);
            #1;
            rd(3'(i), "loadlow_sweep");
        end
        scan("loadlow_scan");

        // Back-to-back writes to one address: last wins, each visible one cycle
        bus.address = 3'd6;
        bus.load    = 1'b1;
        bus.in      = 16'h1234;
        @(posedge clk);
        #1;
        sb.push_back(16'h1234);
        check("b2b_first");
        bus.in = 16'h4321;
        @(posedge clk);
        #1;
        bus.load = 1'b0;
        model[6] = 16'h4321;
        sb.push_back(16'h4321);
        check("b2b_second");

        // Reset priority over a pending write
        reset       = 1'b1;
        bus.load    = 1'b1;
        bus.address = 3'd2;
        bus.in      = 16'hBEEF;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        bus.load = 1'b0;
        for (int i = 0; i < 8; i++) model[i] = 16'h0000;
        sb.push_back(16'h0000);
        check("rstprio_addr2");
        scan("rstprio_scan");

        // Write after reset lands normally
        wr(3'd7, 16'hC0DE, "post_rst_wr");
        scan("post_rst_scan");

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule

// File: doc/ram8_16.md
# ram8_16

Eight-word by 16-bit register file (RAM8) built from the team's 8-way load-steering demux, eight 16-bit registers and an 8-way 16-bit read mux. It is the storage stage that consumes per-word load strobes and feeds the read path. It serves as the leaf memory for the larger RAM64/RAM512 hierarchy and the data-memory path. Writes are synchronous and reads are asynchronous, following the computer's memory model.

## Interface
- WIDTH, 16, data word width; fixed at 16 for this block, present for documentation and checks only.
- DEPTH, 8, number of words; fixed at 8, addressed by a 3-bit address.
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears all eight words on the next rising edge.
- in  input  16  write data.
- load  input  1  write enable; when high, `in` is written to word `address` at the rising edge.
- address  input  3  word select for both write and read.
- out  output  16  contents of word `address` (combinational read).

## Operation
- Storage: eight 16-bit registers, word[0]..word[7].
- Load steering: `load` is demultiplexed by `address` into eight 1-bit load strobes; exactly one strobe equals `load`, the other seven are 0.
- Write: at rising edge of `clk`, if `reset`=0 and `load`=1, then word[address] <= in. All other words hold.
- Hold: if `load`=0 and `reset`=0, all words hold.
- Reset: at rising edge with `reset`=1, all eight words <= 16'h0000. Reset has priority over `load`; no write occurs in a reset cycle.
- Read: out = word[address] through the 8-way 16-bit mux, purely combinational. There is no read enable and no read latency.
- Address decoding is full; all 8 codes are valid, with no out-of-range case.
- No byte enables, no partial writes; always a full 16-bit word.

## Timing
- Reset values: all words 0. `out` = 16'h0000 from the edge that samples `reset`=1 until the first subsequent write.
- Before the first reset, contents are undefined (X in simulation). The bench must reset first.
- Write latency: 1 edge. The value written at edge N is visible on `out` (if `address` selects it) immediately after edge N.
- Read latency: 0 cycles. `out` follows changes in `address` within the same cycle, combinationally.
- Read-during-write, same address: before the edge, `out` shows the old value (no write-through bypass). After the edge, it shows `in`.
- Read-during-write, different address: the read is unaffected.
- Back-to-back writes to the same address on consecutive edges: the last one wins, and each is visible for one cycle.
- Reset asserted mid-operation, with `load`=1 in the same cycle: all words clear, and the pending write is dropped.
- `address`, `in` and `load` must be stable around the rising edge (setup/hold). Glitches between edges affect only `out`, never the stored state.

## Test plan
- Reset then scan: assert `reset` for 1 edge, then read addresses 0..7 with `load`=0 -> `out`=16'h0000 for every address.
- Write all and read back: write word[i] = 16'h1111*i + 16'h0001 for i=0..7 (one per edge), then read 0..7 -> 16'h0001, 16'h1112, ..., 16'h7778.
- Write isolation: after the fill, write 16'hFFFF to address 5 -> address 5 reads 16'hFFFF; addresses 0-4 and 6-7 keep their prior values.
- Read-during-write: address=3 holding 16'hAAAA; set in=16'h5555, load=1 -> `out`=16'hAAAA before the edge and 16'h5555 after it.
- Load low: in=16'hDEAD, load=0, sweep the address across 8 edges -> no word changes.
- Reset priority: reset=1, load=1, address=2, in=16'hBEEF at one edge -> all words 0, and address 2 reads 16'h0000 (not 16'hBEEF).
